// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cpu_pkg
// Description : Shared types and constants for the branch/flag logic.
//               cond_t     - B.cond condition field, ARM encoding.
//               FLAG_N/Z/C/V - bit positions inside the 4-bit NZCV register.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  typedef enum logic [3:0] {
    EQ = 4'h0,
    NE = 4'h1,
    HS = 4'h2,
    LO = 4'h3,
    MI = 4'h4,
    PL = 4'h5,
    VS = 4'h6,
    VC = 4'h7,
    HI = 4'h8,
    LS = 4'h9,
    GE = 4'hA,
    LT = 4'hB,
    GT = 4'hC,
    LE = 4'hD,
    AL = 4'hE,
    NV = 4'hF
  } cond_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/cond_eval.sv
`default_nettype none
// ============================================================================
// Module      : cond_eval
// Description : Purely combinational evaluation of an ARM condition code
//               against a 4-bit NZCV flag value.
// Ports       : cond  (in)  condition field
//               flags (in)  {N,Z,C,V}
//               pass  (out) condition holds
// Revision    : 1.0 - initial release
// ============================================================================
module cond_eval
  import cpu_pkg::*;
(
  input  cond_t      cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  always_comb begin
    n    = flags[FLAG_N];
    z    = flags[FLAG_Z];
    c    = flags[FLAG_C];
    v    = flags[FLAG_V];
    pass = 1'b0;
    case (cond)
      EQ: pass = z;
      NE: pass = ~z;
      HS: pass = c;
      LO: pass = ~c;
      MI: pass = n;
      PL: pass = ~n;
      VS: pass = v;
      VC: pass = ~v;
      HI: pass = c & ~z;
      LS: pass = ~(c & ~z);
      GE: pass = (n == v);
      LT: pass = (n != v);
      GT: pass = ~z & (n == v);
      LE: pass = ~(~z & (n == v));
      AL: pass = 1'b1;
      NV: pass = 1'b1;
    endcase
  end

endmodule : cond_eval
`default_nettype wire

// File: rtl/flag_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : flag_branch_unit
// Description : Architectural NZCV flag register plus conditional-branch
//               resolution (CBZ/CBNZ on the live zero flag, B.cond on the
//               registered flags) and wrapping branch statistics counters.
// Ports       : clk, reset (sync, active-high)
//               zero_detected/negative/carry_out/overflow - live ALU flags
//               set_flags, is_cbz, is_cbnz, is_bcond, cond  - decode info
//               take_branch  - combinational branch select
//               flags        - registered {N,Z,C,V}
//               flags_valid  - sticky, set by first flag-setting op
//               branch_count - conditional branches resolved
//               taken_count  - conditional branches taken
// Revision    : 1.0 - initial release
// ============================================================================
module flag_branch_unit
  import cpu_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 zero_detected,
  input  logic                 negative,
  input  logic                 carry_out,
  input  logic                 overflow,
  input  logic                 set_flags,
  input  logic                 is_cbz,
  input  logic                 is_cbnz,
  input  logic                 is_bcond,
  input  logic [3:0]           cond,
  output logic                 take_branch,
  output logic [3:0]           flags,
  output logic                 flags_valid,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] taken_count
);

  logic [3:0]           flags_q,        flags_d;
  logic                 flags_valid_q,  flags_valid_d;
  logic [CNT_WIDTH-1:0] branch_count_q, branch_count_d;
  logic [CNT_WIDTH-1:0] taken_count_q,  taken_count_d;

  cond_t cond_e;
  logic  cond_pass;
  logic  cond_always;
  logic  is_branch;

  assign cond_e = cond_t'(cond);

  // B.cond always sees the registered flags, so a same-cycle flag write
  // only becomes visible to the following instruction.
  cond_eval u_cond_eval (
    .cond  (cond_e),
    .flags (flags_q),
    .pass  (cond_pass)
  );

  always_comb begin
    cond_always = (cond_e == AL) || (cond_e == NV);
    is_branch   = is_cbz | is_cbnz | is_bcond;
    take_branch = 1'b0;

    // Priority cbz > cbnz > bcond covers illegal multi-hot decodes.
    if (!reset) begin
      if (is_cbz)
        take_branch = zero_detected;
      else if (is_cbnz)
        take_branch = ~zero_detected;
      else if (is_bcond)
        // Flags are meaningless until the first flag-setting op, so only
        // the unconditional encodings may branch before then.
        take_branch = cond_pass & (flags_valid_q | cond_always);
    end

    flags_d       = flags_q;
    flags_valid_d = flags_valid_q;
    if (set_flags) begin
      flags_d[FLAG_N] = negative;
      flags_d[FLAG_Z] = zero_detected;
      flags_d[FLAG_C] = carry_out;
      flags_d[FLAG_V] = overflow;
      flags_valid_d   = 1'b1;
    end

    // Counters wrap naturally at 2^CNT_WIDTH.
    branch_count_d = branch_count_q + {{(CNT_WIDTH-1){1'b0}}, is_branch};
    taken_count_d  = taken_count_q
                   + {{(CNT_WIDTH-1){1'b0}}, is_branch & take_branch};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q        <= 4'b0000;
      flags_valid_q  <= 1'b0;
      branch_count_q <= '0;
      taken_count_q  <= '0;
    end else begin
      flags_q        <= flags_d;
      flags_valid_q  <= flags_valid_d;
      branch_count_q <= branch_count_d;
      taken_count_q  <= taken_count_d;
    end
  end

  assign flags        = flags_q;
  assign flags_valid  = flags_valid_q;
  assign branch_count = branch_count_q;
  assign taken_count  = taken_count_q;

endmodule : flag_branch_unit
`default_nettype wire

// File: tb/tb_flag_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_flag_branch_unit
// Description : Directed self-checking bench for flag_branch_unit, built
//               with CNT_WIDTH=4 so counter wrap is reachable quickly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flag_branch_unit;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          zero_detected, negative, carry_out, overflow;
  logic          set_flags, is_cbz, is_cbnz, is_bcond;
  logic [3:0]    cond;
  logic          take_branch;
  logic [3:0]    flags;
  logic          flags_valid;
  logic [CW-1:0] branch_count, taken_count;

  int n_checks = 0;
  int n_fails  = 0;

  flag_branch_unit #(.CNT_WIDTH(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .zero_detected (zero_detected),
    .negative      (negative),
    .carry_out     (carry_out),
    .overflow      (overflow),
    .set_flags     (set_flags),
    .is_cbz        (is_cbz),
    .is_cbnz       (is_cbnz),
    .is_bcond      (is_bcond),
    .cond          (cond),
    .take_branch   (take_branch),
    .flags         (flags),
    .flags_valid   (flags_valid),
    .branch_count  (branch_count),
    .taken_count   (taken_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    set_flags = 0; is_cbz = 0; is_cbnz = 0; is_bcond = 0; cond = 4'h0;
    zero_detected = 0; negative = 0; carry_out = 0; overflow = 0;
  endtask

  initial begin
    idle();
    reset = 1;
    // Reset gates take_branch even for an AL branch.
    is_bcond = 1; cond = 4'hE;
    #1;
    check("reset_take_al", {31'b0, take_branch}, 32'd0);
    tick();
    tick();
    check("reset_flags", {28'b0, flags}, 32'h0);
    check("reset_valid", {31'b0, flags_valid}, 32'd0);
    check("reset_bcnt", {28'b0, branch_count}, 32'd0);
    check("reset_tcnt", {28'b0, taken_count}, 32'd0);

    // B.cond before any flag-setting op.
    reset = 0; is_bcond = 1; cond = 4'h0; #1;
    check("pre_valid_eq_take", {31'b0, take_branch}, 32'd0);
    check("pre_valid_flag", {31'b0, flags_valid}, 32'd0);
    tick();
    cond = 4'hE; #1;
    check("pre_valid_al_take", {31'b0, take_branch}, 32'd1);
    tick();
    idle(); #1;
    check("non_branch_take", {31'b0, take_branch}, 32'd0);
    check("bcnt_2", {28'b0, branch_count}, 32'd2);
    check("tcnt_1", {28'b0, taken_count}, 32'd1);

    // Flag write: N=0 Z=1 C=1 V=0 -> 0110.
    set_flags = 1; zero_detected = 1; carry_out = 1;
    tick();
    idle(); #1;
    check("flags_0110", {28'b0, flags}, 32'h6);
    check("valid_set", {31'b0, flags_valid}, 32'd1);
    is_bcond = 1; cond = 4'h0; #1;
    check("eq_take", {31'b0, take_branch}, 32'd1);
    tick();
    cond = 4'h8; #1;
    check("hi_take", {31'b0, take_branch}, 32'd0);
    tick();
    cond = 4'h9; #1;
    check("ls_take", {31'b0, take_branch}, 32'd1);
    tick();
    idle(); #1;
    check("bcnt_5", {28'b0, branch_count}, 32'd5);
    check("tcnt_3", {28'b0, taken_count}, 32'd3);

    // Clear flags to 0000 (valid stays 1).
    set_flags = 1;
    tick();
    idle(); #1;
    check("flags_0000", {28'b0, flags}, 32'h0);
    // Same-cycle write N=1 with B.cond LT sees old flags (N==V).
    set_flags = 1; negative = 1; is_bcond = 1; cond = 4'hB; #1;
    check("lt_same_cycle", {31'b0, take_branch}, 32'd0);
    tick();
    set_flags = 0; negative = 0; #1;
    check("lt_next_cycle", {31'b0, take_branch}, 32'd1);
    check("flags_1000", {28'b0, flags}, 32'h8);
    cond = 4'hA; #1;
    check("ge_take", {31'b0, take_branch}, 32'd0);
    cond = 4'hD; #1;
    check("le_take", {31'b0, take_branch}, 32'd1);
    tick();

    // CBZ/CBNZ use live zero; registered Z is 0.
    idle(); is_cbz = 1; zero_detected = 1; #1;
    check("cbz_live_z", {31'b0, take_branch}, 32'd1);
    tick();
    idle(); is_cbnz = 1; zero_detected = 1; #1;
    check("cbnz_live_z", {31'b0, take_branch}, 32'd0);
    tick();
    // Multi-hot decode: cbz wins (zero=0 -> not taken) over AL.
    idle(); is_cbz = 1; is_cbnz = 1; is_bcond = 1; cond = 4'hE; #1;
    check("multi_hot_prio", {31'b0, take_branch}, 32'd0);
    tick();
    idle(); #1;
    check("flags_hold_1000", {28'b0, flags}, 32'h8);
    // 2 + 3 + 2 + 2 + 1 = 10 resolved; taken 1 + 2 + 1 + 1 = 5.
    check("bcnt_10", {28'b0, branch_count}, 32'd10);
    check("tcnt_5", {28'b0, taken_count}, 32'd5);

    // Mid-stream reset with flags 1111.
    set_flags = 1; negative = 1; zero_detected = 1; carry_out = 1; overflow = 1;
    tick();
    idle(); #1;
    check("flags_1111", {28'b0, flags}, 32'hF);
    is_bcond = 1; cond = 4'hE; reset = 1; #1;
    check("reset_mid_take", {31'b0, take_branch}, 32'd0);
    tick();
    check("rst_mid_flags", {28'b0, flags}, 32'h0);
    check("rst_mid_valid", {31'b0, flags_valid}, 32'd0);
    check("rst_mid_bcnt", {28'b0, branch_count}, 32'd0);
    check("rst_mid_tcnt", {28'b0, taken_count}, 32'd0);

    // 16 taken CBZ wrap both 4-bit counters to 0; the 17th gives 1.
    reset = 0; idle(); is_cbz = 1; zero_detected = 1;
    for (int i = 0; i < 16; i++) tick();
    check("wrap_bcnt_0", {28'b0, branch_count}, 32'd0);
    check("wrap_tcnt_0", {28'b0, taken_count}, 32'd0);
    tick();
    check("wrap_bcnt_1", {28'b0, branch_count}, 32'd1);
    check("wrap_tcnt_1", {28'b0, taken_count}, 32'd1);

    // Flags still invalid after reset: LE blocked, NV taken.
    idle(); is_bcond = 1; cond = 4'hD; #1;
    check("pre_valid_le", {31'b0, take_branch}, 32'd0);
    cond = 4'hF; #1;
    check("pre_valid_nv", {31'b0, take_branch}, 32'd1);
    tick();
    idle(); #1;
    check("final_bcnt", {28'b0, branch_count}, 32'd2);
    check("final_tcnt", {28'b0, taken_count}, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_flag_branch_unit
`default_nettype wire

// File: doc/flag_branch_unit.md
Name: flag_branch_unit

Overview:
- Consumer of the 64-bit datapath zero-detect output.
- Holds the architectural NZCV condition-flag register, updated by flag-setting ALU ops (ADDS/SUBS/ANDS).
- Resolves conditional control flow: CBZ/CBNZ use the live zero flag; B.cond uses the registered flags.
- Drives take_branch to the PC-select mux and keeps wrapping branch statistics counters for debug.

Parameters:
- CNT_WIDTH, 32, width of the branch-resolved and branch-taken statistics counters.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- zero_detected  input  1  live zero flag of the current ALU result.
- negative  input  1  live ALU result bit 63.
- carry_out  input  1  live ALU adder carry out.
- overflow  input  1  live ALU signed overflow.
- set_flags  input  1  current instruction writes NZCV.
- is_cbz  input  1  current instruction is CBZ.
- is_cbnz  input  1  current instruction is CBNZ.
- is_bcond  input  1  current instruction is B.cond.
- cond  input  4  B.cond condition field, ARM encoding.
- take_branch  output  1  combinational; select branch target this cycle.
- flags  output  4  registered {N,Z,C,V}.
- flags_valid  output  1  registered; 1 once any flag-setting op has committed since reset.
- branch_count  output  CNT_WIDTH  registered; number of conditional branches resolved.
- taken_count  output  CNT_WIDTH  registered; number of conditional branches taken.

Behaviour:
- Reset: flags=4'b0000, flags_valid=0, branch_count=0, taken_count=0. take_branch is 0 on any cycle with reset=1, regardless of the other inputs.
- Flag update: on posedge with set_flags=1 and reset=0:
  - flags <= {negative, zero_detected, carry_out, overflow};
  - flags_valid <= 1 (sticky until reset).
  - With set_flags=0, flags hold.
- CBZ/CBNZ (combinational, same cycle):
  - CBZ: take_branch = zero_detected.
  - CBNZ: take_branch = ~zero_detected.
  - The registered Z flag is not used for these.
- B.cond (combinational) evaluates the registered flags, never the live inputs:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 HS: C
  - 3 LO: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&!Z
  - 9 LS: !(C&!Z)
  - A GE: N==V
  - B LT: N!=V
  - C GT: !Z&(N==V)
  - D LE: !(!Z&(N==V))
  - E AL: 1
  - F NV: 1
- B.cond before any flag-setting op: flags_valid=0 forces take_branch=0 for cond 0x0–0xD. AL/NV are still taken.
- Non-branch cycles: take_branch=0 whenever is_cbz, is_cbnz and is_bcond are all 0.
- Simultaneous set_flags and is_bcond: the branch evaluates the pre-update flags; the new flags become visible next cycle.
- Multiple is_* asserted (illegal decode): priority is is_cbz > is_cbnz > is_bcond. Counters increment once.
- Counters: on posedge with reset=0 and any of is_cbz/is_cbnz/is_bcond:
  - branch_count += 1;
  - taken_count += take_branch.
  - Both wrap modulo 2^CNT_WIDTH; no saturation, no overflow flag.
- Reset asserted mid-stream: the next edge clears all state. The branch under evaluation in that cycle is not counted.
- No latency on take_branch (same cycle). Flags have 1-cycle write-to-read latency.

Decomposition:
- Shared package cpu_pkg holds:
  - typedef enum logic [3:0] cond_t, with values EQ..NV in the encoding above;
  - localparams FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0 (bit indices into flags).
- One natural sub-module: cond_eval, purely combinational. Inputs are cond_t and the 4-bit flags; output is the pass bit.
- The top level holds the flag register, flags_valid, take_branch muxing and counters.

Test Plan:
- Reset then B.cond EQ (cond=0) -> take_branch=0, flags_valid=0. B.cond AL (cond=E) -> take_branch=1. After these two branches: branch_count=2, taken_count=1.
- set_flags=1 with zero_detected=1, negative=0, carry_out=1, overflow=0 -> next cycle flags=4'b0110, flags_valid=1. Then B.cond EQ -> 1, HI -> 0, LS -> 1.
- Same cycle set_flags=1 (N=1,V=0) and B.cond LT, with prior flags 4'b0000 and flags_valid=1 -> take_branch=0 that cycle. Repeat B.cond LT next cycle -> 1.
- CBZ with zero_detected=1 while registered Z=0 -> take_branch=1. CBNZ with zero_detected=1 -> take_branch=0. Flags unchanged throughout.
- CNT_WIDTH=4: 16 consecutive taken CBZ from reset -> branch_count and taken_count wrap to 0. The 17th -> both equal 1.
- Assert reset during a stream with flags=4'b1111 and counters nonzero -> after one edge: flags=0, flags_valid=0, counters=0, and take_branch=0 while reset is high.
